// File: rtl/pll_dyn_ctrl.sv
// Sequencer for a dynamically reconfigurable rPLL: power-on lock, divider changes, lock qualification and retry.
// Latency: a request is accepted in one cycle; lock is declared 2 + LOCK_STABLE cycles after lock_i settles high.
// Backpressure: req_ready is high only in IDLE; requests arriving while busy are ignored and must be held.
module pll_dyn_ctrl #(
    parameter int unsigned INIT_FDIV    = 0,
    parameter int unsigned INIT_IDIV    = 0,
    parameter bit          SEL_INVERT   = 1'b1,
    parameter int unsigned RESET_CYCLES = 16,
    parameter int unsigned LOCK_STABLE  = 256,
    parameter int unsigned LOCK_TIMEOUT = 65535,
    parameter int unsigned MAX_RETRY    = 3,
    parameter bit          AUTO_RELOCK  = 1'b1
) (
    input  logic       clkin,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [5:0] req_fdiv,
    input  logic [5:0] req_idiv,
    output logic       pll_reset,
    output logic [5:0] fdiv,
    output logic [5:0] idiv,
    input  logic       lock_i,
    output logic       locked,
    output logic       busy,
    output logic       err
);

    localparam int RW = $clog2(RESET_CYCLES) + 1;
    localparam int SW = $clog2(LOCK_STABLE) + 1;
    localparam int TW = $clog2(LOCK_TIMEOUT) + 1;
    localparam int YW = $clog2(MAX_RETRY + 1) + 1;

    localparam logic [RW-1:0] RST_LAST   = RW'(RESET_CYCLES - 1);
    localparam logic [SW-1:0] STABLE_N   = SW'(LOCK_STABLE);
    localparam logic [TW-1:0] TIMEOUT_N  = TW'(LOCK_TIMEOUT);
    localparam logic [YW-1:0] RETRY_MAX  = YW'(MAX_RETRY);
    // The rPLL dynamic select ports take the inverted code when SEL_INVERT is set.
    localparam logic [5:0]    SEL_MASK   = SEL_INVERT ? 6'h3F : 6'h00;
    localparam logic [5:0]    INIT_F_ENC = 6'(INIT_FDIV) ^ SEL_MASK;
    localparam logic [5:0]    INIT_I_ENC = 6'(INIT_IDIV) ^ SEL_MASK;

    typedef enum logic [1:0] {
        RST_HOLD  = 2'd0,
        WAIT_LOCK = 2'd1,
        IDLE      = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [RW-1:0]   rst_cnt_q, rst_cnt_d;
    logic [SW-1:0]   stable_q, stable_d, stable_nxt;
    logic [TW-1:0]   to_cnt_q, to_cnt_d, to_nxt;
    logic [YW-1:0]   retry_q, retry_d;
    logic            locked_q, locked_d;
    logic            err_q, err_d;
    logic            pll_reset_q, pll_reset_d;
    logic [5:0]      fdiv_q, fdiv_d;
    logic [5:0]      idiv_q, idiv_d;
    logic            sync1_q, sync2_q;
    logic            lock_s;

    // Two-flop synchronizer bringing the PLL lock flag into the clkin domain.
    always_ff @(posedge clkin) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= lock_i;
            sync2_q <= sync1_q;
        end
    end

    assign lock_s = sync2_q;

    // Next-state logic: reset hold timing, lock qualification, retry and request handling.
    always_comb begin
        state_d     = state_q;
        rst_cnt_d   = '0;
        stable_d    = '0;
        to_cnt_d    = '0;
        retry_d     = retry_q;
        locked_d    = locked_q;
        err_d       = err_q;
        fdiv_d      = fdiv_q;
        idiv_d      = idiv_q;
        stable_nxt  = lock_s ? (stable_q + 1'b1) : '0;
        to_nxt      = to_cnt_q + 1'b1;

        case (state_q)
            RST_HOLD: begin
                if (rst_cnt_q == RST_LAST) begin
                    state_d = WAIT_LOCK;
                end else begin
                    rst_cnt_d = rst_cnt_q + 1'b1;
                end
            end
            WAIT_LOCK: begin
                stable_d = stable_nxt;
                to_cnt_d = to_nxt;
                // Success is tested first so it wins over a simultaneous timeout.
                if (stable_nxt >= STABLE_N) begin
                    state_d  = IDLE;
                    locked_d = 1'b1;
                    retry_d  = '0;
                    err_d    = 1'b0;
                end else if (to_nxt >= TIMEOUT_N) begin
                    if (retry_q < RETRY_MAX) begin
                        retry_d = retry_q + 1'b1;
                        state_d = RST_HOLD;
                    end else begin
                        err_d    = 1'b1;
                        locked_d = 1'b0;
                        state_d  = IDLE;
                    end
                end
            end
            IDLE: begin
                // A new request outranks a coincident lock loss.
                if (req_valid) begin
                    fdiv_d   = req_fdiv ^ SEL_MASK;
                    idiv_d   = req_idiv ^ SEL_MASK;
                    locked_d = 1'b0;
                    err_d    = 1'b0;
                    retry_d  = '0;
                    state_d  = RST_HOLD;
                end else if (locked_q && !lock_s) begin
                    locked_d = 1'b0;
                    if (AUTO_RELOCK) begin
                        retry_d = '0;
                        state_d = RST_HOLD;
                    end
                end
            end
            default: begin
                state_d = RST_HOLD;
            end
        endcase

        pll_reset_d = (state_d == RST_HOLD);
    end

    // State and output registers; reset restarts the power-on sequence with the initial codes.
    always_ff @(posedge clkin) begin
        if (reset) begin
            state_q     <= RST_HOLD;
            rst_cnt_q   <= '0;
            stable_q    <= '0;
            to_cnt_q    <= '0;
            retry_q     <= '0;
            locked_q    <= 1'b0;
            err_q       <= 1'b0;
            pll_reset_q <= 1'b1;
            fdiv_q      <= INIT_F_ENC;
            idiv_q      <= INIT_I_ENC;
        end else begin
            state_q     <= state_d;
            rst_cnt_q   <= rst_cnt_d;
            stable_q    <= stable_d;
            to_cnt_q    <= to_cnt_d;
            retry_q     <= retry_d;
            locked_q    <= locked_d;
            err_q       <= err_d;
            pll_reset_q <= pll_reset_d;
            fdiv_q      <= fdiv_d;
            idiv_q      <= idiv_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign pll_reset = pll_reset_q;
    assign fdiv      = fdiv_q;
    assign idiv      = idiv_q;
    assign locked    = locked_q;
    assign err       = err_q;

endmodule

// File: tb/tb_pll_dyn_ctrl.sv
// Bench for pll_dyn_ctrl: scenario tasks with random codes and lock timing against arithmetic expectations.
// Latency: expectations are expressed in clkin cycles derived from the reset/lock/timeout parameters.
// Backpressure: requests are only issued when req_ready is high; a held request while busy is checked as ignored.
module tb_pll_dyn_ctrl;

    localparam int RC = 4;
    localparam int LS = 8;
    localparam int LT = 100;
    localparam int MR = 2;

    logic       clk;
    logic       reset;
    logic       req_valid;
    logic       req_ready;
    logic [5:0] req_fdiv;
    logic [5:0] req_idiv;
    logic       pll_reset;
    logic [5:0] fdiv;
    logic [5:0] idiv;
    logic       lock_i;
    logic       locked;
    logic       busy;
    logic       err;

    int tests = 0;
    int fails = 0;
    logic [5:0] cur_f, cur_i;

    pll_dyn_ctrl #(
        .INIT_FDIV(5), .INIT_IDIV(1), .SEL_INVERT(1'b1), .RESET_CYCLES(RC),
        .LOCK_STABLE(LS), .LOCK_TIMEOUT(LT), .MAX_RETRY(MR), .AUTO_RELOCK(1'b1)
    ) dut (
        .clkin(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_fdiv(req_fdiv), .req_idiv(req_idiv), .pll_reset(pll_reset),
        .fdiv(fdiv), .idiv(idiv), .lock_i(lock_i), .locked(locked),
        .busy(busy), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [5:0] enc(input logic [5:0] c);
        return ~c;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_pll_fall(output int n);
        n = 0;
        while (pll_reset === 1'b1 && n < 64) begin tick(); n++; end
        if (pll_reset !== 1'b0) n = -1;
    endtask

    task automatic wait_locked(input int bound, output int n);
        n = 0;
        while (locked !== 1'b1 && n < bound) begin tick(); n++; end
        if (locked !== 1'b1) n = -1;
    endtask

    task automatic handshake(input logic [5:0] f, input logic [5:0] i);
        req_fdiv  = f;
        req_idiv  = i;
        req_valid = 1'b1;
        lock_i    = 1'b0;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid = 1'b0; lock_i = 1'b0; req_fdiv = '0; req_idiv = '0;
        repeat (3) tick();
        tests++; if (pll_reset !== 1'b1) begin fails++; $display("FAIL rst_pll_reset got=%b want=1", pll_reset); end
        tests++; if (locked !== 1'b0) begin fails++; $display("FAIL rst_locked got=%b want=0", locked); end
        tests++; if (err !== 1'b0) begin fails++; $display("FAIL rst_err got=%b want=0", err); end
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL rst_busy got=%b want=1", busy); end
        tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL rst_req_ready got=%b want=0", req_ready); end
        tests++; if (fdiv !== 6'h3A) begin fails++; $display("FAIL rst_fdiv got=%h want=3a", fdiv); end
        tests++; if (idiv !== 6'h3E) begin fails++; $display("FAIL rst_idiv got=%h want=3e", idiv); end
    endtask

    task automatic test_power_on(input int d);
        int n;
        bit codes_moved;
        codes_moved = 1'b0;
        lock_i = 1'b0;
        reset  = 1'b0;
        wait_pll_fall(n);
        tests++; if (n != RC) begin fails++; $display("FAIL pwr_reset_len got=%0d want=%0d", n, RC); end
        repeat (d) begin
            tick();
            if (fdiv !== 6'h3A || idiv !== 6'h3E || locked !== 1'b0) codes_moved = 1'b1;
        end
        lock_i = 1'b1;
        wait_locked(40, n);
        tests++; if (n != 2 + LS) begin fails++; $display("FAIL pwr_lock_latency got=%0d want=%0d", n, 2 + LS); end
        tests++; if (codes_moved) begin fails++; $display("FAIL pwr_codes_stable got=moved want=steady"); end
        tests++; if ({fdiv, idiv} !== {6'h3A, 6'h3E}) begin fails++; $display("FAIL pwr_codes got=%h/%h want=3a/3e", fdiv, idiv); end
        tests++; if ({busy, req_ready, err} !== 3'b010) begin fails++; $display("FAIL pwr_idle_flags got=%b want=010", {busy, req_ready, err}); end
        cur_f = 6'd5;
        cur_i = 6'd1;
    endtask

    task automatic test_request(input logic [5:0] f, input logic [5:0] i, input int d);
        int n;
        tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL req_ready_pre got=%b want=1", req_ready); end
        handshake(f, i);
        tests++; if ({locked, pll_reset, busy, req_ready, err} !== 5'b01100) begin
            fails++; $display("FAIL req_hs_flags got=%b want=01100", {locked, pll_reset, busy, req_ready, err}); end
        tests++; if ({fdiv, idiv} !== {enc(f), enc(i)}) begin
            fails++; $display("FAIL req_codes got=%h/%h want=%h/%h", fdiv, idiv, enc(f), enc(i)); end
        // A request held while busy must not disturb the codes in flight.
        req_fdiv = ~f; req_idiv = ~i; req_valid = 1'b1;
        tick(); tick();
        req_valid = 1'b0;
        wait_pll_fall(n);
        tests++; if (n + 2 != RC) begin fails++; $display("FAIL req_reset_len got=%0d want=%0d", n + 2, RC); end
        tests++; if ({fdiv, idiv} !== {enc(f), enc(i)}) begin
            fails++; $display("FAIL req_busy_ignored got=%h/%h want=%h/%h", fdiv, idiv, enc(f), enc(i)); end
        repeat (d) tick();
        lock_i = 1'b1;
        wait_locked(40, n);
        tests++; if (n != 2 + LS) begin fails++; $display("FAIL req_lock_latency got=%0d want=%0d", n, 2 + LS); end
        tests++; if ({busy, req_ready, err} !== 3'b010) begin fails++; $display("FAIL req_idle_flags got=%b want=010", {busy, req_ready, err}); end
        cur_f = f;
        cur_i = i;
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 5; k++)
            test_request(6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)), $urandom_range(1, 30));
    endtask

    task automatic test_glitch(input int h);
        int n;
        bit early;
        early = 1'b0;
        handshake(6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)));
        wait_pll_fall(n);
        repeat ($urandom_range(1, 20)) tick();
        lock_i = 1'b1;
        repeat (h) begin tick(); if (locked !== 1'b0) early = 1'b1; end
        lock_i = 1'b0;
        tick();
        lock_i = 1'b1;
        wait_locked(40, n);
        tests++; if (early) begin fails++; $display("FAIL glitch_early_lock got=1 want=0"); end
        tests++; if (n != 2 + LS) begin fails++; $display("FAIL glitch_relock got=%0d want=%0d h=%0d", n, 2 + LS, h); end
        cur_f = req_fdiv;
        cur_i = req_idiv;
    endtask

    task automatic test_lock_loss();
        int k;
        int n;
        lock_i = 1'b0;
        k = 0;
        while (locked === 1'b1 && k < 10) begin tick(); k++; end
        tests++; if (k < 2 || k > 3) begin fails++; $display("FAIL loss_latency got=%0d want=2..3", k); end
        tests++; if (pll_reset !== 1'b1) begin fails++; $display("FAIL loss_relock_start got=%b want=1", pll_reset); end
        wait_pll_fall(n);
        tests++; if (n != RC) begin fails++; $display("FAIL loss_reset_len got=%0d want=%0d", n, RC); end
        tests++; if ({fdiv, idiv} !== {enc(cur_f), enc(cur_i)}) begin
            fails++; $display("FAIL loss_codes got=%h/%h want=%h/%h", fdiv, idiv, enc(cur_f), enc(cur_i)); end
        repeat ($urandom_range(1, 20)) tick();
        lock_i = 1'b1;
        wait_locked(40, n);
        tests++; if (n != 2 + LS) begin fails++; $display("FAIL loss_relock got=%0d want=%0d", n, 2 + LS); end
    endtask

    task automatic test_timeout_fail();
        int k;
        int highs;
        int rises;
        logic prev;
        handshake(6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)));
        highs = (pll_reset === 1'b1) ? 1 : 0;
        rises = highs;
        prev  = pll_reset;
        k = 0;
        while (err !== 1'b1 && k < 600) begin
            tick(); k++;
            if (pll_reset === 1'b1) highs++;
            if (pll_reset === 1'b1 && prev !== 1'b1) rises++;
            prev = pll_reset;
        end
        tests++; if (k != (MR + 1) * (RC + LT)) begin fails++; $display("FAIL fail_time got=%0d want=%0d", k, (MR + 1) * (RC + LT)); end
        tests++; if (rises != MR + 1) begin fails++; $display("FAIL fail_attempts got=%0d want=%0d", rises, MR + 1); end
        tests++; if (highs != (MR + 1) * RC) begin fails++; $display("FAIL fail_reset_cycles got=%0d want=%0d", highs, (MR + 1) * RC); end
        tests++; if ({locked, busy, req_ready, pll_reset} !== 4'b0010) begin
            fails++; $display("FAIL fail_flags got=%b want=0010", {locked, busy, req_ready, pll_reset}); end
        repeat (20) tick();
        tests++; if ({err, pll_reset, req_ready} !== 3'b101) begin
            fails++; $display("FAIL fail_no_relock got=%b want=101", {err, pll_reset, req_ready}); end
        test_request(6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)), 5);
    endtask

    task automatic test_timeout_edge();
        int n;
        // Lock qualifies on exactly the timeout cycle: success must win.
        handshake(6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)));
        wait_pll_fall(n);
        repeat (LT - 2 - LS) tick();
        lock_i = 1'b1;
        wait_locked(20, n);
        tests++; if (n != 2 + LS) begin fails++; $display("FAIL edge_success got=%0d want=%0d", n, 2 + LS); end
        tests++; if (err !== 1'b0) begin fails++; $display("FAIL edge_err got=%b want=0", err); end
        // One cycle later and the timeout fires first, forcing a retry.
        handshake(6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)));
        wait_pll_fall(n);
        repeat (LT - 1 - LS) tick();
        lock_i = 1'b1;
        repeat (LS + 1) tick();
        tests++; if ({pll_reset, locked} !== 2'b10) begin fails++; $display("FAIL edge_retry got=%b want=10", {pll_reset, locked}); end
        wait_pll_fall(n);
        tests++; if (n != RC) begin fails++; $display("FAIL edge_retry_len got=%0d want=%0d", n, RC); end
        wait_locked(40, n);
        tests++; if (n != LS) begin fails++; $display("FAIL edge_retry_lock got=%0d want=%0d", n, LS); end
        cur_f = req_fdiv;
        cur_i = req_idiv;
    endtask

    task automatic test_reset_mid();
        int n;
        handshake(6'd9, 6'd2);
        tests++; if ({fdiv, idiv} !== {6'h36, 6'h3D}) begin fails++; $display("FAIL mid_req_codes got=%h/%h want=36/3d", fdiv, idiv); end
        wait_pll_fall(n);
        repeat (5) tick();
        reset = 1'b1;
        tick();
        tests++; if ({pll_reset, locked, err, busy, req_ready} !== 5'b10010) begin
            fails++; $display("FAIL mid_flags got=%b want=10010", {pll_reset, locked, err, busy, req_ready}); end
        tests++; if ({fdiv, idiv} !== {6'h3A, 6'h3E}) begin fails++; $display("FAIL mid_codes got=%h/%h want=3a/3e", fdiv, idiv); end
        tick();
        test_power_on($urandom_range(5, 20));
    endtask

    initial begin
        test_reset();
        test_power_on(10);
        test_request(6'd9, 6'd2, 10);
        test_back_to_back();
        test_glitch(5);
        test_glitch($urandom_range(1, 7));
        test_lock_loss();
        test_timeout_fail();
        test_timeout_edge();
        test_lock_loss();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
